// File: rtl/clk_div_ramp_ctrl.sv
// clk_div_ramp_ctrl
//   Sequencer that walks an integer clock divider from its current divide value
//   to a requested target in steps of at most MAX_STEP. After each accepted step
//   it waits DWELL_CYCLES clocks before issuing the next one.
//   Optional feature macro: CLK_DIV_RAMP_RETARGET_EN. When it is defined, a new
//   target can be accepted during the dwell phase.
module clk_div_ramp_ctrl #(
   parameter int DIV_VALUE_WIDTH   = 4,
   parameter int DEFAULT_DIV_VALUE = 0,
   parameter int MAX_STEP          = 2,
   parameter int DWELL_CYCLES      = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [DIV_VALUE_WIDTH-1:0] tgt_div_i,
   input  logic                       tgt_valid_i,
   output logic                       tgt_ready_o,
   output logic [DIV_VALUE_WIDTH-1:0] div_o,
   output logic                       div_valid_o,
   input  logic                       div_ready_i,
   output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int W = DIV_VALUE_WIDTH;
   // A divide value of 0 is meaningless to the divider, so it is treated as 1.
   localparam logic [W-1:0] DEF_NORM = (DEFAULT_DIV_VALUE == 0) ? W'(1) : W'(DEFAULT_DIV_VALUE);
   // A step at least as large as the whole value range degenerates to a direct jump.
   localparam bit           DIRECT_JUMP = (MAX_STEP >= (1 << W));
   localparam logic [W:0]   STEP_W1 = DIRECT_JUMP ? '0 : (W+1)'(MAX_STEP);
   localparam int           CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (DWELL_CYCLES > 0) ? CNT_W'(DWELL_CYCLES - 1) : '0;

   generate
      if (MAX_STEP <= 0) begin : g_bad_max_step
         $error("clk_div_ramp_ctrl: MAX_STEP must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP  = 2'd1,
      S_DWELL = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     tgt_q, tgt_d;
   logic [W-1:0]     cur_q, cur_d;
   logic [W-1:0]     div_q, div_d;
   logic             div_valid_q, div_valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic [W-1:0]     tgt_norm;
   logic [W-1:0]     tgt_eff;

   function automatic logic [W-1:0] norm(input logic [W-1:0] v);
      return (v == '0) ? W'(1) : v;
   endfunction

   // Next value on the way from cur to tgt. Done in W+1 bits so the sums
   // cannot wrap; the subtraction is only taken when it stays above tgt.
   function automatic logic [W-1:0] next_step(input logic [W-1:0] cur, input logic [W-1:0] tgt);
      logic [W:0] c;
      logic [W:0] t;
      logic [W:0] s;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      if (DIRECT_JUMP) begin
         s = t;
      end else if (t > c) begin
         s = ((c + STEP_W1) <= t) ? (c + STEP_W1) : t;
      end else begin
         s = (c >= (t + STEP_W1)) ? (c - STEP_W1) : t;
      end
      return s[W-1:0];
   endfunction

`ifdef CLK_DIV_RAMP_RETARGET_EN
   assign tgt_ready_o = (state_q == S_IDLE) || (state_q == S_DWELL);
`else
   assign tgt_ready_o = (state_q == S_IDLE);
`endif
   assign busy_o      = (state_q != S_IDLE);
   assign div_o       = div_q;
   assign div_valid_o = div_valid_q;
   assign cur_div_o   = cur_q;
   assign done_o      = done_q;

   assign accept   = tgt_valid_i && tgt_ready_o;
   assign tgt_norm = norm(tgt_div_i);

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      cur_d       = cur_q;
      div_d       = div_q;
      div_valid_d = div_valid_q;
      done_d      = 1'b0;
      cnt_d       = cnt_q;
      tgt_eff     = tgt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               tgt_d = tgt_norm;
               if (tgt_norm == cur_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = S_STEP;
                  div_d       = next_step(cur_q, tgt_norm);
                  div_valid_d = 1'b1;
               end
            end
         end
         S_STEP: begin
            // div_o is frozen until the divider takes it.
            if (div_ready_i) begin
               cur_d       = div_q;
               div_valid_d = 1'b0;
               if (DWELL_CYCLES == 0) begin
                  if (div_q == tgt_q) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     div_d       = next_step(div_q, tgt_q);
                     div_valid_d = 1'b1;
                  end
               end else begin
                  state_d = S_DWELL;
                  cnt_d   = '0;
               end
            end
         end
         S_DWELL: begin
`ifdef CLK_DIV_RAMP_RETARGET_EN
            // A retarget on the final dwell cycle already steers the decision below.
            if (accept) begin
               tgt_d   = tgt_norm;
               tgt_eff = tgt_norm;
            end
`endif
            if (cnt_q == CNT_LAST) begin
               if (cur_q == tgt_eff) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = S_STEP;
                  div_d       = next_step(cur_q, tgt_eff);
                  div_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d     = S_IDLE;
            div_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight step immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         tgt_q       <= DEF_NORM;
         cur_q       <= DEF_NORM;
         div_q       <= DEF_NORM;
         div_valid_q <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         cur_q       <= cur_d;
         div_q       <= div_d;
         div_valid_q <= div_valid_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// tb_clk_div_ramp_ctrl
//   Bench for clk_div_ramp_ctrl with W=4, DEFAULT=1, MAX_STEP=2, DWELL=4.
//   Expectations for the retarget case follow CLK_DIV_RAMP_RETARGET_EN.
module tb_clk_div_ramp_ctrl;

   localparam int W     = 4;
   localparam int MS    = 2;
   localparam int DWELL = 4;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [W-1:0] tgt_div_i;
   logic         tgt_valid_i;
   logic         tgt_ready_o;
   logic [W-1:0] div_o;
   logic         div_valid_o;
   logic         div_ready_i;
   logic [W-1:0] cur_div_o;
   logic         busy_o;
   logic         done_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   clk_div_ramp_ctrl #(
      .DIV_VALUE_WIDTH  (W),
      .DEFAULT_DIV_VALUE(1),
      .MAX_STEP         (MS),
      .DWELL_CYCLES     (DWELL)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .tgt_div_i  (tgt_div_i),
      .tgt_valid_i(tgt_valid_i),
      .tgt_ready_o(tgt_ready_o),
      .div_o      (div_o),
      .div_valid_o(div_valid_o),
      .div_ready_i(div_ready_i),
      .cur_div_o  (cur_div_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference plan: the full list of step values from c to t.
   int exp_q[$];
   task automatic plan(input int c, input int t);
      exp_q.delete();
      while (c != t) begin
         if (t > c) c = (c + MS < t) ? c + MS : t;
         else       c = (c - MS > t) ? c - MS : t;
         exp_q.push_back(c);
      end
   endtask

   // Called just after the accepting edge (cycle 0); observes cycles 1.. until done_o.
   task automatic wait_ramp(output int nhs, output int first, output int done_cyc, output int saw_busy);
      nhs = 0; first = 0; done_cyc = -1; saw_busy = 0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (busy_o) saw_busy = 1;
         if (div_valid_o && div_ready_i) begin
            nhs++;
            if (nhs == 1) first = int'(div_o);
         end
         if (done_o) begin
            done_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic offer(input int t);
      @(negedge clk);
      tgt_div_i   = W'(t);
      tgt_valid_i = 1'b1;
      @(posedge clk);
      #1 tgt_valid_i = 1'b0;
   endtask

   typedef struct {
      int tgt;
      int first;
      int nsteps;
      int done_cyc;
      int exp_cur;
      int exp_busy;
   } vec_t;
   vec_t vecs[7];

   initial begin
      int nhs, first, done_cyc, saw_busy, ok, n, model_cur;

      // Rows run back to back; each starts from the previous row's end value.
      // With ready tied high, done_o lands at cycle 5*steps+1.
      vecs[0] = '{7,  3,  3, 16, 7,  1};
      vecs[1] = '{0,  5,  3, 16, 1,  1};
      vecs[2] = '{1,  0,  0, 1,  1,  0};
      vecs[3] = '{15, 3,  7, 36, 15, 1};
      vecs[4] = '{14, 14, 1, 6,  14, 1};
      vecs[5] = '{2,  12, 6, 31, 2,  1};
      vecs[6] = '{3,  3,  1, 6,  3,  1};

      rst_i = 1'b1; tgt_div_i = '0; tgt_valid_i = 1'b0; div_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_i = 1'b0;
      @(negedge clk);
      check("rst_cur",   int'(cur_div_o),   1);
      check("rst_ready", int'(tgt_ready_o), 1);
      check("rst_valid", int'(div_valid_o), 0);
      check("rst_busy",  int'(busy_o),      0);
      check("rst_done",  int'(done_o),      0);

      // Table-driven ramps.
      for (int i = 0; i < 7; i++) begin
         offer(vecs[i].tgt);
         wait_ramp(nhs, first, done_cyc, saw_busy);
         $display("vec %0d: tgt=%0d steps=%0d first=%0d done_cyc=%0d cur=%0d",
                  i, vecs[i].tgt, nhs, first, done_cyc, cur_div_o);
         check("vec_nsteps", nhs,            vecs[i].nsteps);
         check("vec_first",  first,          vecs[i].first);
         check("vec_done",   done_cyc,       vecs[i].done_cyc);
         check("vec_cur",    int'(cur_div_o), vecs[i].exp_cur);
         check("vec_busy",   saw_busy,       vecs[i].exp_busy);
         @(negedge clk);
         check("vec_done_width", int'(done_o), 0);
         check("vec_idle",       int'(busy_o), 0);
      end

      // Back-pressure stall from cur=1, then reset mid-handshake.
      rst_i = 1'b1; #1 rst_i = 1'b0;
      div_ready_i = 1'b0;
      offer(7);
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(div_valid_o == 1'b1 && div_o == 4'd3 && cur_div_o == 4'd1)) ok = 0;
      end
      $display("stall: valid=%0d div=%0d cur=%0d", div_valid_o, div_o, cur_div_o);
      check("stall_hold", ok, 1);
      rst_i = 1'b1;
      #1;
      $display("reset mid-stall: valid=%0d cur=%0d busy=%0d", div_valid_o, cur_div_o, busy_o);
      check("rst_mid_valid", int'(div_valid_o), 0);
      check("rst_mid_cur",   int'(cur_div_o),   1);
      check("rst_mid_busy",  int'(busy_o),      0);
      @(negedge clk) rst_i = 1'b0;
      div_ready_i = 1'b1;

      // Retarget offered during the first dwell (cur=3).
      offer(7);
      @(negedge clk);
      @(negedge clk);
      tgt_div_i = 4'd2; tgt_valid_i = 1'b1;
`ifdef CLK_DIV_RAMP_RETARGET_EN
      check("retgt_ready", int'(tgt_ready_o), 1);
      @(posedge clk);
      #1 tgt_valid_i = 1'b0;
      wait_ramp(nhs, first, done_cyc, saw_busy);
      $display("retarget on: steps=%0d first=%0d done_cyc=%0d cur=%0d", nhs, first, done_cyc, cur_div_o);
      check("retgt_nsteps", nhs,             1);
      check("retgt_first",  first,           2);
      check("retgt_done",   done_cyc,        9);
      check("retgt_cur",    int'(cur_div_o), 2);
`else
      check("retgt_ready", int'(tgt_ready_o), 0);
      n = 2;
      while (!tgt_ready_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      $display("retarget off: ready at cycle %0d cur=%0d", n, cur_div_o);
      check("retgt_wait_cyc", n,               16);
      check("retgt_wait_cur", int'(cur_div_o), 7);
      @(posedge clk);
      #1 tgt_valid_i = 1'b0;
      wait_ramp(nhs, first, done_cyc, saw_busy);
      $display("retarget off: steps=%0d first=%0d done_cyc=%0d cur=%0d", nhs, first, done_cyc, cur_div_o);
      check("retgt_nsteps", nhs,             3);
      check("retgt_first",  first,           5);
      check("retgt_done",   done_cyc,        16);
      check("retgt_cur",    int'(cur_div_o), 2);
`endif
      model_cur = 2;

      // Randomized targets and back-pressure against the reference plan.
      for (int tr = 0; tr < 25; tr++) begin
         int t, tn, cyc, got_done, last_hs, prev_valid, prev_pending, nsteps;
         logic [W-1:0] prev_div;
         t  = int'($urandom_range(0, 15));
         tn = (t == 0) ? 1 : t;
         plan(model_cur, tn);
         nsteps = exp_q.size();
         @(negedge clk);
         check("rnd_ready", int'(tgt_ready_o), 1);
         tgt_div_i = W'(t); tgt_valid_i = 1'b1;
         @(posedge clk);
         #1 tgt_valid_i = 1'b0;
         cyc = 0; got_done = 0; last_hs = -1; prev_valid = 0; prev_pending = 0; prev_div = '0;
         while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check("rnd_cur", int'(cur_div_o), model_cur);
            if (prev_pending) check("rnd_hold", int'(div_valid_o && div_o == prev_div), 1);
            if (div_valid_o) check("rnd_real_step", int'(div_o != cur_div_o), 1);
            if (div_valid_o && !prev_valid && last_hs >= 0)
               check("rnd_dwell_gap", cyc - last_hs, DWELL + 1);
            div_ready_i = ($urandom_range(0, 3) != 0);
            if (div_valid_o && div_ready_i) begin
               if (exp_q.size() == 0) begin
                  check("rnd_extra_step", int'(div_o), -1);
               end else begin
                  check("rnd_step", int'(div_o), exp_q[0]);
                  model_cur = exp_q.pop_front();
               end
               last_hs = cyc;
               prev_pending = 0;
            end else begin
               prev_pending = int'(div_valid_o);
            end
            prev_valid = int'(div_valid_o);
            prev_div   = div_o;
            if (done_o) begin
               got_done = 1;
               check("rnd_done_plan", exp_q.size(), 0);
               check("rnd_done_cur",  int'(cur_div_o), tn);
            end
         end
         check("rnd_finished", got_done, 1);
         $display("rnd %0d: tgt=%0d steps=%0d cycles=%0d cur=%0d", tr, t, nsteps, cyc, cur_div_o);
         model_cur = tn;
         div_ready_i = 1'b1;
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
